// File: rtl/riscv_pkg.sv
// Shared definitions for the core: datapath width, load funct3 encodings and
// the write-back buffer state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    StEmpty,
    StHeld
  } wb_state_t;

endpackage

// File: rtl/load_ext.sv
// Load data extender: picks the byte/half addressed by the offset and sign- or
// zero-extends it according to funct3. Purely combinational.
module load_ext #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] ext_data
);
  import riscv_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (offset)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = offset[1] ? data[31:16] : data[15:0];
  end

  // Unlisted funct3 codes fall through to a plain word load.
  always_comb begin
    case (funct3)
      F3_LB:   ext_data = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
      F3_LH:   ext_data = {{(XLEN - 16){half_sel[15]}}, half_sel};
      F3_LBU:  ext_data = {{(XLEN - 8){1'b0}}, byte_sel};
      F3_LHU:  ext_data = {{(XLEN - 16){1'b0}}, half_sel};
      default: ext_data = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: merges ALU and load results into the single register-file
// write port, parking a colliding load in a one-entry buffer; counts retirements.
module wb_stage #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NUM  = 32,
  localparam int unsigned AW  = $clog2(NUM)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_offset,
  output logic [AW-1:0]   addr_w,
  output logic [XLEN-1:0] data_w,
  output logic            pend_valid,
  output logic [AW-1:0]   pend_rd,
  output logic [63:0]     instret
);
  import riscv_pkg::*;

  wb_state_t       state_q;
  logic [XLEN-1:0] buf_data_q;
  logic [XLEN-1:0] ext_data;
  logic            lsu_fire;

  load_ext #(
    .XLEN(XLEN)
  ) u_load_ext (
    .data    (lsu_data),
    .funct3  (lsu_funct3),
    .offset  (lsu_offset),
    .ext_data(ext_data)
  );

  assign lsu_ready  = (state_q == StEmpty);
  assign pend_valid = (state_q == StHeld);
  assign lsu_fire   = lsu_valid && lsu_ready;

  // ALU results can never stall, so they always win the write port; a load
  // arriving alongside one is parked until the first ALU-free cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StEmpty;
      buf_data_q <= '0;
      pend_rd    <= '0;
      addr_w     <= '0;
      data_w     <= '0;
      instret    <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (alu_valid) begin
            addr_w  <= alu_rd;
            data_w  <= alu_data;
            instret <= instret + 64'd1;
            if (lsu_fire) begin
              buf_data_q <= ext_data;
              pend_rd    <= lsu_rd;
              state_q    <= StHeld;
            end
          end else if (lsu_fire) begin
            addr_w  <= lsu_rd;
            data_w  <= ext_data;
            instret <= instret + 64'd1;
          end else begin
            addr_w <= '0;
          end
        end
        StHeld: begin
          if (alu_valid) begin
            addr_w <= alu_rd;
            data_w <= alu_data;
          end else begin
            addr_w  <= pend_rd;
            data_w  <= buf_data_q;
            pend_rd <= '0;
            state_q <= StEmpty;
          end
          instret <= instret + 64'd1;
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// checked every cycle against a queue-based behavioural model.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [2:0]  lsu_funct3 = '0;
  logic [1:0]  lsu_offset = '0;
  logic [4:0]  addr_w;
  logic [31:0] data_w;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [63:0] instret;

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage #(
    .XLEN(32),
    .NUM (32)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_funct3(lsu_funct3),
    .lsu_offset(lsu_offset),
    .addr_w    (addr_w),
    .data_w    (data_w),
    .pend_valid(pend_valid),
    .pend_rd   (pend_rd),
    .instret   (instret)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extension computed arithmetically from the load-type rules.
  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  res_t        pend_q[$];
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [63:0] m_instret = '0;
  bit          m_fire;
  res_t        m_ld;
  res_t        m_ent;

  // Model: ALU result always issues; otherwise the oldest parked load, then a
  // fresh load. A load can only be accepted while nothing is parked.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_addr = '0;
      m_data = '0;
      m_instret = '0;
      pend_q.delete();
    end else begin
      m_fire = lsu_valid && (pend_q.size() == 0);
      m_ld.rd = lsu_rd;
      m_ld.data = ext_model(lsu_data, lsu_funct3, lsu_offset);
      if (alu_valid) begin
        m_addr = alu_rd;
        m_data = alu_data;
        m_instret = m_instret + 1;
        if (m_fire) pend_q.push_back(m_ld);
      end else if (pend_q.size() > 0) begin
        m_ent = pend_q.pop_front();
        m_addr = m_ent.rd;
        m_data = m_ent.data;
        m_instret = m_instret + 1;
      end else if (m_fire) begin
        m_addr = m_ld.rd;
        m_data = m_ld.data;
        m_instret = m_instret + 1;
      end else begin
        m_addr = '0;
      end
    end
  end

  always @(negedge clock) begin
    check("model addr_w", 64'(addr_w), 64'(m_addr));
    check("model data_w", 64'(data_w), 64'(m_data));
    check("model instret", instret, m_instret);
    check("model lsu_ready", 64'(lsu_ready), 64'(pend_q.size() == 0));
    check("model pend_valid", 64'(pend_valid), 64'(pend_q.size() != 0));
    check("model pend_rd", 64'(pend_rd), 64'((pend_q.size() != 0) ? pend_q[0].rd : 5'd0));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  logic [2:0]  ext_f3[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
  logic [1:0]  ext_off[5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ext_exp[5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                              32'h80FF_7F01};

  initial begin
    bit acc;
    // Reset state
    tick();
    tick();
    @(negedge clock);
    check("reset addr_w", 64'(addr_w), 64'd0);
    check("reset data_w", 64'(data_w), 64'd0);
    check("reset instret", instret, 64'd0);
    check("reset lsu_ready", 64'(lsu_ready), 64'd1);
    #1 reset_n = 1'b1;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    clear_inputs();
    @(negedge clock);
    check("alu addr_w", 64'(addr_w), 64'd5);
    check("alu data_w", 64'(data_w), 64'h1234);
    check("alu instret", instret, 64'd1);
    tick();
    @(negedge clock);
    check("alu idle addr_w", 64'(addr_w), 64'd0);

    // Load extension
    for (int k = 0; k < 5; k++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(k + 10); lsu_data = 32'h80FF_7F01;
      lsu_funct3 = ext_f3[k]; lsu_offset = ext_off[k];
      tick();
      clear_inputs();
      @(negedge clock);
      check("ext addr_w", 64'(addr_w), 64'(k + 10));
      check("ext data_w", 64'(data_w), 64'(ext_exp[k]));
    end

    // Async reset with a load held in the buffer
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h22; lsu_funct3 = 3'b010; lsu_offset = 2'd0;
    tick();
    clear_inputs();
    check("pre-reset pend_valid", 64'(pend_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset addr_w", 64'(addr_w), 64'd0);
    check("midreset data_w", 64'(data_w), 64'd0);
    check("midreset instret", instret, 64'd0);
    check("midreset lsu_ready", 64'(lsu_ready), 64'd1);
    check("midreset pend_valid", 64'(pend_valid), 64'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;

    // Collision
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB; lsu_funct3 = 3'b010; lsu_offset = 2'd0;
    tick();
    lsu_valid = 1'b0; alu_rd = 5'd6; alu_data = 32'hC;
    @(negedge clock);
    check("coll1 addr_w", 64'(addr_w), 64'd3);
    check("coll1 data_w", 64'(data_w), 64'hA);
    check("coll1 pend_valid", 64'(pend_valid), 64'd1);
    check("coll1 pend_rd", 64'(pend_rd), 64'd4);
    check("coll1 lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    clear_inputs();
    @(negedge clock);
    check("coll2 addr_w", 64'(addr_w), 64'd6);
    check("coll2 data_w", 64'(data_w), 64'hC);
    check("coll2 pend_valid", 64'(pend_valid), 64'd1);
    check("coll2 pend_rd", 64'(pend_rd), 64'd4);
    check("coll2 lsu_ready", 64'(lsu_ready), 64'd0);
    tick();
    @(negedge clock);
    check("coll3 addr_w", 64'(addr_w), 64'd4);
    check("coll3 data_w", 64'(data_w), 64'hB);
    check("coll3 pend_valid", 64'(pend_valid), 64'd0);
    check("coll3 lsu_ready", 64'(lsu_ready), 64'd1);
    check("coll3 instret", instret, 64'd3);

    // rd = 0 retires without writing
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    tick();
    clear_inputs();
    @(negedge clock);
    check("rd0 addr_w", 64'(addr_w), 64'd0);
    check("rd0 instret", instret, 64'd4);

    // Back-to-back loads
    for (int k = 0; k < 4; k++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(k + 1); lsu_data = $urandom;
      lsu_funct3 = 3'b010; lsu_offset = 2'd0;
      tick();
      @(negedge clock);
      check("b2b lsu_ready", 64'(lsu_ready), 64'd1);
      check("b2b addr_w", 64'(addr_w), 64'(k + 1));
    end
    check("b2b instret", instret, 64'd8);
    clear_inputs();
    tick();

    // Randomized traffic; an unaccepted load keeps its payload stable.
    acc = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd = 5'($urandom);
      alu_data = $urandom;
      if (!(lsu_valid && !acc)) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd = 5'($urandom);
        lsu_data = $urandom;
        lsu_funct3 = 3'($urandom);
        lsu_offset = 2'($urandom);
        if (lsu_funct3 == 3'b001 || lsu_funct3 == 3'b101) lsu_offset[0] = 1'b0;
        else if (lsu_funct3 != 3'b000 && lsu_funct3 != 3'b100) lsu_offset = 2'd0;
      end
      @(negedge clock);
      acc = lsu_ready;
      tick();
    end
    clear_inputs();
    repeat (4) tick();
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
